// File: rtl/riscv_reset_ctrl.sv
// Board reset/ready sequencer: synchronizes and debounces the reset button,
// stretches it into a clean core reset, then gates ready and counts run cycles.
module riscv_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int RDY_DELAY       = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk_in,
    input  logic                 rstn_in,
    input  logic                 btn_in,
    output logic                 rst_out,
    output logic                 rdy_out,
    output logic [CNT_WIDTH-1:0] run_cycles_out,
    output logic [1:0]           state_out
);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] WARM_LAST = 16'(RDY_DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_sync;
    logic                   btn_db_q, btn_db_d;
    logic [15:0]            db_cnt_q, db_cnt_d;
    logic [15:0]            hold_cnt_q, hold_cnt_d;
    logic [15:0]            warm_cnt_q, warm_cnt_d;
    state_e                 state_q, state_d;
    logic                   rst_q, rst_d;
    logic                   rdy_q, rdy_d;
    logic [CNT_WIDTH-1:0]   run_q, run_d;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = btn_in;
    end

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q;
        if (btn_sync == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_sync;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 16'd1;
        end
    end

    // FSM acts on the debounced level registered before this edge
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        warm_cnt_d = warm_cnt_q;
        run_d      = run_q;
        unique case (state_q)
            HOLD: begin
                if (btn_db_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = WARMUP;
                    warm_cnt_d = '0;
                    run_d      = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            WARMUP: begin
                if (btn_db_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (warm_cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (btn_db_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else if (run_q != '1) begin
                    run_d = run_q + 1'b1;
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase
        rst_d = (state_d == HOLD);
        rdy_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            sync_q     <= '0;
            btn_db_q   <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            warm_cnt_q <= '0;
            state_q    <= HOLD;
            rst_q      <= 1'b1;
            rdy_q      <= 1'b0;
            run_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            state_q    <= state_d;
            rst_q      <= rst_d;
            rdy_q      <= rdy_d;
            run_q      <= run_d;
        end
    end

    assign rst_out        = rst_q;
    assign rdy_out        = rdy_q;
    assign run_cycles_out = run_q;
    assign state_out      = state_q;

endmodule

// File: tb/tb_riscv_reset_ctrl.sv
// Bench for riscv_reset_ctrl: a default instance and a narrow-counter,
// long-warmup instance, both checked against a quiet-time reference model.
module tb_riscv_reset_ctrl;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        btn;
    logic        rst_a, rdy_a;
    logic [1:0]  st_a;
    logic [31:0] run_a;
    logic        rst_b, rdy_b;
    logic [1:0]  st_b;
    logic [3:0]  run_b;

    riscv_reset_ctrl u_def (
        .clk_in(clk), .rstn_in(rstn), .btn_in(btn),
        .rst_out(rst_a), .rdy_out(rdy_a),
        .run_cycles_out(run_a), .state_out(st_a)
    );

    riscv_reset_ctrl #(.RDY_DELAY(12), .CNT_WIDTH(4)) u_alt (
        .clk_in(clk), .rstn_in(rstn), .btn_in(btn),
        .rst_out(rst_b), .rdy_out(rdy_b),
        .run_cycles_out(run_b), .state_out(st_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: per instance, the button level seen after the synchronizer,
    // the accepted level, and the count of consecutive edges with the
    // accepted level low ("quiet"). State and run count follow from quiet.
    int     rdel [2] = '{4, 12};
    longint rmax [2] = '{64'hffff_ffff, 64'd15};
    logic [7:0] m_pipe [2];
    logic       m_db   [2];
    int         m_mis  [2];
    int         m_quiet[2];
    longint     m_run  [2];

    function automatic void model_step(int i, logic r, logic b);
        logic s_old, db_old;
        longint q;
        if (!r) begin
            m_pipe[i] = '0; m_db[i] = 1'b0; m_mis[i] = 0;
            m_quiet[i] = 0; m_run[i] = 0;
            return;
        end
        s_old = m_pipe[i][S-1];
        db_old = m_db[i];
        if (s_old == db_old) m_mis[i] = 0;
        else if (m_mis[i] + 1 == D) begin
            m_db[i] = s_old; m_mis[i] = 0;
        end else m_mis[i]++;
        m_pipe[i] = {m_pipe[i][6:0], b};
        if (db_old) m_quiet[i] = 0;
        else begin
            m_quiet[i]++;
            q = longint'(m_quiet[i]);
            if (q > H + rdel[i])
                m_run[i] = (q - H - rdel[i] > rmax[i]) ? rmax[i] : q - H - rdel[i];
            else if (q >= H)
                m_run[i] = 0;
        end
    endfunction

    function automatic logic [1:0] m_state(int i);
        if (m_quiet[i] < H) return 2'd0;
        if (m_quiet[i] < H + rdel[i]) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [35:0] exp_a();
        logic [1:0] s = m_state(0);
        return {s == 2'd0, s == 2'd2, s, 32'(m_run[0])};
    endfunction

    function automatic logic [7:0] exp_b();
        logic [1:0] s = m_state(1);
        return {s == 2'd0, s == 2'd2, s, 4'(m_run[1])};
    endfunction

    task automatic tick(input logic r, input logic b);
        rstn = r;
        btn  = b;
        @(posedge clk);
        model_step(0, r, b);
        model_step(1, r, b);
        #1;
    endtask

    task automatic test_reset();
        for (int e = 1; e <= 5; e++) begin
            tick(1'b0, 1'b0);
            n_vec++;
            if ({rst_a, rdy_a, st_a, run_a} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
                n_err++;
                $display("FAIL reset_def e%0d: got %h want %h", e,
                         {rst_a, rdy_a, st_a, run_a}, {1'b1, 1'b0, 2'd0, 32'd0});
            end
            n_vec++;
            if ({rst_b, rdy_b, st_b, run_b} !== 8'b1000_0000) begin
                n_err++;
                $display("FAIL reset_alt e%0d: got %h want 80", e,
                         {rst_b, rdy_b, st_b, run_b});
            end
        end
    endtask

    task automatic test_power_on();
        for (int e = 1; e <= 30; e++) begin
            tick(1'b1, 1'b0);
            n_vec++;
            if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                n_err++;
                $display("FAIL poweron_def e%0d: got %h want %h", e,
                         {rst_a, rdy_a, st_a, run_a}, exp_a());
            end
            n_vec++;
            if ({rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL poweron_alt e%0d: got %h want %h", e,
                         {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
            if (e == 16) begin
                n_vec++;
                if ({rst_a, st_a} !== 3'b001) begin
                    n_err++;
                    $display("FAIL poweron_e16: rst/state got %b want 001", {rst_a, st_a});
                end
            end
            if (e == 20) begin
                n_vec++;
                if ({rdy_a, st_a} !== 3'b110) begin
                    n_err++;
                    $display("FAIL poweron_e20: rdy/state got %b want 110", {rdy_a, st_a});
                end
            end
            if (e == 30) begin
                n_vec++;
                if (run_a !== 32'd10) begin
                    n_err++;
                    $display("FAIL poweron_e30: run got %0d want 10", run_a);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic        pat [20];
        logic [31:0] prev;
        for (int k = 0; k < 3; k++) pat[k] = 1'b1;
        pat[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pat[4 + 2*k] = 1'b1;
            pat[5 + 2*k] = 1'b0;
        end
        for (int k = 16; k < 20; k++) pat[k] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            prev = run_a;
            tick(1'b1, pat[k]);
            n_vec++;
            if ({rst_a, rdy_a} !== 2'b01 || run_a !== prev + 32'd1) begin
                n_err++;
                $display("FAIL bounce k%0d: rst/rdy %b run %0d want 01 run %0d",
                         k, {rst_a, rdy_a}, run_a, prev + 32'd1);
            end
            n_vec++;
            if ({rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL bounce_alt k%0d: got %h want %h", k,
                         {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
        end
    endtask

    task automatic test_press();
        logic [31:0] run_e6 = '0;
        for (int e = 1; e <= 7; e++) begin
            tick(1'b1, 1'b1);
            n_vec++;
            if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                n_err++;
                $display("FAIL press_def e%0d: got %h want %h", e,
                         {rst_a, rdy_a, st_a, run_a}, exp_a());
            end
            if (e == 6) run_e6 = run_a;
            if (e == 6) begin
                n_vec++;
                if (rst_a !== 1'b0) begin
                    n_err++;
                    $display("FAIL press_e6: rst got %b want 0", rst_a);
                end
            end
            if (e == 7) begin
                n_vec++;
                if ({rst_a, rdy_a, st_a} !== 4'b1000 || run_a !== run_e6) begin
                    n_err++;
                    $display("FAIL press_e7: rst/rdy/st %b run %0d want 1000 run %0d",
                             {rst_a, rdy_a, st_a}, run_a, run_e6);
                end
            end
        end
    endtask

    task automatic test_long_press();
        for (int e = 1; e <= 100; e++) begin
            tick(1'b1, 1'b1);
            n_vec++;
            if (rst_a !== 1'b1 || {rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL long_hold e%0d: rst %b alt %h want 1 alt %h",
                         e, rst_a, {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
        end
        for (int r = 1; r <= 26; r++) begin
            tick(1'b1, 1'b0);
            n_vec++;
            if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                n_err++;
                $display("FAIL long_rel_def r%0d: got %h want %h", r,
                         {rst_a, rdy_a, st_a, run_a}, exp_a());
            end
            if (r == 21) begin
                n_vec++;
                if (rst_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL long_r21: rst got %b want 1", rst_a);
                end
            end
            if (r == 22) begin
                n_vec++;
                if (rst_a !== 1'b0 || run_a !== 32'd0) begin
                    n_err++;
                    $display("FAIL long_r22: rst %b run %0d want 0 0", rst_a, run_a);
                end
            end
            if (r == 26) begin
                n_vec++;
                if (rdy_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL long_r26: rdy got %b want 1", rdy_a);
                end
            end
        end
    endtask

    task automatic test_warmup_press();
        for (int e = 1; e <= 10; e++) tick(1'b1, 1'b1);
        for (int r = 1; r <= 23; r++) begin
            tick(1'b1, 1'b0);
            n_vec++;
            if ({rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL warm_rel r%0d: got %h want %h", r,
                         {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
        end
        n_vec++;
        if ({rst_b, st_b} !== 3'b001) begin
            n_err++;
            $display("FAIL warm_entry: rst/state got %b want 001", {rst_b, st_b});
        end
        for (int p = 1; p <= 10; p++) begin
            tick(1'b1, 1'b1);
            n_vec++;
            if (rdy_b !== 1'b0 || {rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL warm_press p%0d: got %h want %h", p,
                         {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
            n_vec++;
            if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                n_err++;
                $display("FAIL warm_press_def p%0d: got %h want %h", p,
                         {rst_a, rdy_a, st_a, run_a}, exp_a());
            end
            if (p == 7) begin
                n_vec++;
                if ({rst_b, st_b, rst_a} !== 4'b1001) begin
                    n_err++;
                    $display("FAIL warm_p7: rst_b/st_b/rst_a got %b want 1001",
                             {rst_b, st_b, rst_a});
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        for (int e = 1; e <= 40; e++) tick(1'b1, 1'b0);
        n_vec++;
        if (st_a !== 2'd2 || {rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
            n_err++;
            $display("FAIL midrun_pre: got %h want %h",
                     {rst_a, rdy_a, st_a, run_a}, exp_a());
        end
        tick(1'b0, 1'b0);
        n_vec++;
        if ({rst_a, rdy_a, st_a, run_a} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
            n_err++;
            $display("FAIL midrun_rst_def: got %h want %h",
                     {rst_a, rdy_a, st_a, run_a}, {1'b1, 1'b0, 2'd0, 32'd0});
        end
        n_vec++;
        if ({rst_b, rdy_b, st_b, run_b} !== 8'h80) begin
            n_err++;
            $display("FAIL midrun_rst_alt: got %h want 80", {rst_b, rdy_b, st_b, run_b});
        end
    endtask

    task automatic test_saturation();
        for (int e = 1; e <= 63; e++) begin
            tick(1'b1, 1'b0);
            n_vec++;
            if ({rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                n_err++;
                $display("FAIL sat_alt e%0d: got %h want %h", e,
                         {rst_b, rdy_b, st_b, run_b}, exp_b());
            end
            if (e == 42 || e >= 43) begin
                n_vec++;
                if (run_b !== ((e == 42) ? 4'd14 : 4'd15)) begin
                    n_err++;
                    $display("FAIL sat_value e%0d: run got %0d want %0d", e, run_b,
                             (e == 42) ? 14 : 15);
                end
            end
        end
        n_vec++;
        if (run_a !== 32'd43) begin
            n_err++;
            $display("FAIL sat_def_wide: run got %0d want 43", run_a);
        end
    endtask

    task automatic test_random();
        int   len;
        logic lvl;
        logic b;
        for (int k = 0; k < 120; k++) begin
            len = $urandom_range(1, 40);
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) len = -1;
            if (len < 0) begin
                tick(1'b0, lvl);
                n_vec++;
                if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                    n_err++;
                    $display("FAIL rand_rst_def k%0d: got %h want %h", k,
                             {rst_a, rdy_a, st_a, run_a}, exp_a());
                end
            end else begin
                for (int j = 0; j < len; j++) begin
                    b = lvl;
                    if ($urandom_range(0, 7) == 0) b = ~lvl;
                    tick(1'b1, b);
                    n_vec++;
                    if ({rst_a, rdy_a, st_a, run_a} !== exp_a()) begin
                        n_err++;
                        $display("FAIL rand_def k%0d j%0d: got %h want %h", k, j,
                                 {rst_a, rdy_a, st_a, run_a}, exp_a());
                    end
                    n_vec++;
                    if ({rst_b, rdy_b, st_b, run_b} !== exp_b()) begin
                        n_err++;
                        $display("FAIL rand_alt k%0d j%0d: got %h want %h", k, j,
                                 {rst_b, rdy_b, st_b, run_b}, exp_b());
                    end
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        btn  = 1'b0;
        test_reset();
        test_power_on();
        test_bounce();
        test_press();
        test_long_press();
        test_warmup_press();
        test_midrun_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
